vertex_rotator: RTL and testbench

Pipelined, parametrised rotation engine for the AR card's 3D path. It accepts a group of N_VERT vertices together with one sin/cos pair and an axis select, and rotates the vertices one per cycle through a two-stage multiply / round-saturate pipeline. It returns the rotated group on a valid/ready output port, along with a saturation flag. It sits between the model/vertex store and the projection stage, and replaces the fixed three-vertex, Y-axis-only combinational rotator.

---
 rtl/vertex_rotator_if.sv | 28 ++
 rtl/vertex_rotator.sv | 152 +++++++++++++++
 tb/tb_vertex_rotator.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vertex_rotator_if.sv
// rtl/vertex_rotator_if.sv - group handshake bundle between vertex store, rotator and projection stage
interface vertex_rotator_if #(
   parameter int COORD_W = 8,
   parameter int OUT_W   = 9,
   parameter int TRIG_W  = 16,
   parameter int N_VERT  = 3
);
   logic                          in_valid;
   logic                          in_ready;
   logic [N_VERT*3*COORD_W-1:0]   in_verts;
   logic signed [TRIG_W-1:0]      sin_val;
   logic signed [TRIG_W-1:0]      cos_val;
   logic [1:0]                    axis;
   logic                          out_valid;
   logic                          out_ready;
   logic [N_VERT*3*OUT_W-1:0]     out_verts;
   logic                          out_sat;

   modport master (
      output in_valid, in_verts, sin_val, cos_val, axis, out_ready,
      input  in_ready, out_valid, out_verts, out_sat
   );

   modport slave (
      input  in_valid, in_verts, sin_val, cos_val, axis, out_ready,
      output in_ready, out_valid, out_verts, out_sat
   );
endinterface

// File: rtl/vertex_rotator.sv
// rtl/vertex_rotator.sv - two-stage multiply / round-saturate rotator, one vertex per cycle
module vertex_rotator #(
   parameter int COORD_W   = 8,
   parameter int OUT_W     = 9,
   parameter int TRIG_W    = 16,
   parameter int TRIG_FRAC = 14,
   parameter int N_VERT    = 3
) (
   input logic           clk_in,
   input logic           rst_n_in,
   vertex_rotator_if.slave bus
);
   localparam int PW = COORD_W + TRIG_W;
   localparam int SW = PW + 2;
   localparam int CW = $clog2(N_VERT + 1);
   localparam logic signed [SW-1:0] RND    = SW'(2 ** (TRIG_FRAC - 1));
   localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [SW-1:0] SAT_LO = SW'(-(2 ** (OUT_W - 1)));

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                       state;
   logic [N_VERT*3*COORD_W-1:0]  verts_q;
   logic signed [TRIG_W-1:0]     sin_q, cos_q;
   logic [1:0]                   axis_q;
   logic [CW-1:0]                cnt, p_idx;
   logic                         p_valid;
   logic signed [PW-1:0]         p_ac, p_bs, p_as, p_bc;
   logic signed [COORD_W-1:0]    r_x, r_y, r_z;
   logic [N_VERT*3*OUT_W-1:0]    out_verts_q;
   logic                         out_sat_q, out_valid_q;

   function automatic logic [OUT_W:0] rnd_sat(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] r;
      r = (v + RND) >>> TRIG_FRAC;
      if (r > SAT_HI)      rnd_sat = {1'b1, SAT_HI[OUT_W-1:0]};
      else if (r < SAT_LO) rnd_sat = {1'b1, SAT_LO[OUT_W-1:0]};
      else                 rnd_sat = {1'b0, r[OUT_W-1:0]};
   endfunction

   // Every axis reduces to a' = a*c - b*s, b' = a*s + b*c over a pair (a,b); Y uses (z,x).
   logic [CW-1:0]             sel;
   logic signed [COORD_W-1:0] v_x, v_y, v_z, op_a, op_b;
   always_comb begin
      sel = (cnt < CW'(N_VERT)) ? cnt : '0;
      v_x = verts_q[(int'(sel)*3+0)*COORD_W +: COORD_W];
      v_y = verts_q[(int'(sel)*3+1)*COORD_W +: COORD_W];
      v_z = verts_q[(int'(sel)*3+2)*COORD_W +: COORD_W];
      case (axis_q)
         2'd0:    begin op_a = v_y; op_b = v_z; end
         2'd1:    begin op_a = v_z; op_b = v_x; end
         default: begin op_a = v_x; op_b = v_y; end
      endcase
   end

   logic signed [SW-1:0]    sum_a, sum_b;
   logic [OUT_W:0]          rs_a, rs_b;
   logic signed [OUT_W-1:0] n_x, n_y, n_z;
   logic                    clip;
   always_comb begin
      sum_a = SW'(p_ac) - SW'(p_bs);
      sum_b = SW'(p_as) + SW'(p_bc);
      rs_a  = rnd_sat(sum_a);
      rs_b  = rnd_sat(sum_b);
      n_x   = OUT_W'(r_x);
      n_y   = OUT_W'(r_y);
      n_z   = OUT_W'(r_z);
      clip  = 1'b0;
      case (axis_q)
         2'd0: begin n_y = rs_a[OUT_W-1:0]; n_z = rs_b[OUT_W-1:0]; clip = rs_a[OUT_W] | rs_b[OUT_W]; end
         2'd1: begin n_z = rs_a[OUT_W-1:0]; n_x = rs_b[OUT_W-1:0]; clip = rs_a[OUT_W] | rs_b[OUT_W]; end
         2'd2: begin n_x = rs_a[OUT_W-1:0]; n_y = rs_b[OUT_W-1:0]; clip = rs_a[OUT_W] | rs_b[OUT_W]; end
         default: clip = 1'b0;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state       <= IDLE;
         verts_q     <= '0;
         sin_q       <= '0;
         cos_q       <= '0;
         axis_q      <= '0;
         cnt         <= '0;
         p_idx       <= '0;
         p_valid     <= 1'b0;
         p_ac        <= '0;
         p_bs        <= '0;
         p_as        <= '0;
         p_bc        <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         out_verts_q <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  verts_q   <= bus.in_verts;
                  sin_q     <= bus.sin_val;
                  cos_q     <= bus.cos_val;
                  axis_q    <= bus.axis;
                  cnt       <= '0;
                  p_valid   <= 1'b0;
                  out_sat_q <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (cnt < CW'(N_VERT)) begin
                  p_ac    <= PW'(op_a) * PW'(cos_q);
                  p_bs    <= PW'(op_b) * PW'(sin_q);
                  p_as    <= PW'(op_a) * PW'(sin_q);
                  p_bc    <= PW'(op_b) * PW'(cos_q);
                  r_x     <= v_x;
                  r_y     <= v_y;
                  r_z     <= v_z;
                  p_idx   <= cnt;
                  p_valid <= 1'b1;
                  cnt     <= cnt + CW'(1);
               end else begin
                  p_valid <= 1'b0;
               end
               if (p_valid) begin
                  out_verts_q[(int'(p_idx)*3+0)*OUT_W +: OUT_W] <= n_x;
                  out_verts_q[(int'(p_idx)*3+1)*OUT_W +: OUT_W] <= n_y;
                  out_verts_q[(int'(p_idx)*3+2)*OUT_W +: OUT_W] <= n_z;
                  if (clip) out_sat_q <= 1'b1;
                  if (p_idx == CW'(N_VERT - 1)) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_verts = out_verts_q;
   assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_vertex_rotator.sv
// tb/tb_vertex_rotator.sv - scoreboard bench for vertex_rotator
module tb_vertex_rotator;
   localparam int COORD_W   = 8;
   localparam int OUT_W     = 9;
   localparam int TRIG_W    = 16;
   localparam int TRIG_FRAC = 14;
   localparam int N_VERT    = 3;
   localparam int IW        = N_VERT * 3 * COORD_W;
   localparam int OWD       = N_VERT * 3 * OUT_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vertex_rotator_if #(.COORD_W(COORD_W), .OUT_W(OUT_W), .TRIG_W(TRIG_W), .N_VERT(N_VERT)) bus ();

   vertex_rotator #(
      .COORD_W(COORD_W), .OUT_W(OUT_W), .TRIG_W(TRIG_W), .TRIG_FRAC(TRIG_FRAC), .N_VERT(N_VERT)
   ) dut (
      .clk_in(clk),
      .rst_n_in(rst_n),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [OWD:0] sb[$];
   logic [OWD:0] e;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int rs(input longint v, inout bit clip);
      longint r, hi, lo;
      r  = (v + (longint'(1) << (TRIG_FRAC - 1))) >>> TRIG_FRAC;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      if (r > hi) begin clip = 1'b1; return int'(hi); end
      if (r < lo) begin clip = 1'b1; return int'(lo); end
      return int'(r);
   endfunction

   function automatic logic [OWD:0] model(input logic [IW-1:0] v, input int s, input int c, input logic [1:0] ax);
      logic [OWD-1:0] o;
      bit clip;
      int x, y, z, nx, ny, nz;
      o = '0;
      clip = 1'b0;
      for (int i = 0; i < N_VERT; i++) begin
         x = int'($signed(v[(i*3+0)*COORD_W +: COORD_W]));
         y = int'($signed(v[(i*3+1)*COORD_W +: COORD_W]));
         z = int'($signed(v[(i*3+2)*COORD_W +: COORD_W]));
         nx = x; ny = y; nz = z;
         case (ax)
            2'd0: begin
               ny = rs(longint'(y) * c - longint'(z) * s, clip);
               nz = rs(longint'(y) * s + longint'(z) * c, clip);
            end
            2'd1: begin
               nx = rs(longint'(x) * c + longint'(z) * s, clip);
               nz = rs(-longint'(x) * s + longint'(z) * c, clip);
            end
            2'd2: begin
               nx = rs(longint'(x) * c - longint'(y) * s, clip);
               ny = rs(longint'(x) * s + longint'(y) * c, clip);
            end
            default: ;
         endcase
         o[(i*3+0)*OUT_W +: OUT_W] = OUT_W'(nx);
         o[(i*3+1)*OUT_W +: OUT_W] = OUT_W'(ny);
         o[(i*3+2)*OUT_W +: OUT_W] = OUT_W'(nz);
      end
      return {clip, o};
   endfunction

   function automatic logic [IW-1:0] grp(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
      return {COORD_W'(z2), COORD_W'(y2), COORD_W'(x2),
              COORD_W'(z1), COORD_W'(y1), COORD_W'(x1),
              COORD_W'(z0), COORD_W'(y0), COORD_W'(x0)};
   endfunction

   function automatic logic [OWD-1:0] opk(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
      return {OUT_W'(z2), OUT_W'(y2), OUT_W'(x2),
              OUT_W'(z1), OUT_W'(y1), OUT_W'(x1),
              OUT_W'(z0), OUT_W'(y0), OUT_W'(x0)};
   endfunction

   task automatic send(input logic [IW-1:0] v, input int s, input int c, input logic [1:0] ax);
      int n = 0;
      while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
      bus.in_verts = v;
      bus.sin_val  = TRIG_W'(s);
      bus.cos_val  = TRIG_W'(c);
      bus.axis     = ax;
      bus.in_valid = 1'b1;
      sb.push_back(model(v, s, c, ax));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
      if (sb.size() != 0) check("drain_timeout", 64'd0, 64'd1);
      #1;
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      if (!bus.out_valid) check(tag, 64'd0, 64'd1);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("verts", 64'(bus.out_verts), 64'(e[OWD-1:0]));
            check("sat", 64'(bus.out_sat), 64'(e[OWD]));
         end
      end
   end

   initial begin
      #200000;
      check("global_timeout", 64'd0, 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int n;
      logic [OWD-1:0] snap;
      logic [IW-1:0]  g0;
      g0 = grp(10, 20, 30, -5, 7, -128, 127, 0, 1);
      bus.in_valid  = 1'b0;
      bus.in_verts  = '0;
      bus.sin_val   = '0;
      bus.cos_val   = '0;
      bus.axis      = '0;
      bus.out_ready = 1'b1;

      #12;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_verts", 64'(bus.out_verts), 64'd0);
      check("rst_out_sat", 64'(bus.out_sat), 64'd0);
      #8 rst_n = 1'b1;
      @(posedge clk); #1;

      send(g0, 0, 16384, 2'd2);
      wait_valid("identity_timeout", n);
      check("latency", 64'(n), 64'd4);
      drain();
      check("identity_direct", 64'(bus.out_verts), 64'(opk(10, 20, 30, -5, 7, -128, 127, 0, 1)));

      send(g0, 16384, 0, 2'd2); drain();
      check("rotz_v0", 64'(bus.out_verts[3*OUT_W-1:0]), 64'({OUT_W'(30), OUT_W'(10), OUT_W'(-20)}));
      send(g0, 16384, 0, 2'd0); drain();
      check("rotx_v0", 64'(bus.out_verts[3*OUT_W-1:0]), 64'({OUT_W'(20), OUT_W'(-30), OUT_W'(10)}));
      send(g0, 16384, 0, 2'd1); drain();
      check("roty_v0", 64'(bus.out_verts[3*OUT_W-1:0]), 64'({OUT_W'(-10), OUT_W'(20), OUT_W'(30)}));

      send(grp(1, 0, 0, -1, 0, 0, 3, 0, 0), 0, 8192, 2'd2); drain();
      check("round", 64'(bus.out_verts), 64'(opk(1, 0, 0, 0, 0, 0, 2, 0, 0)));

      send(grp(-128, -128, 0, 0, 0, 0, 1, 2, 3), -32768, -32768, 2'd2); drain();
      check("sat_v0", 64'(bus.out_verts[3*OUT_W-1:0]), 64'({OUT_W'(0), OUT_W'(255), OUT_W'(0)}));
      check("sat_flag", 64'(bus.out_sat), 64'd1);
      send(g0, 0, 16384, 2'd2); drain();
      check("sat_clear", 64'(bus.out_sat), 64'd0);

      send(g0, 12345, -777, 2'd3); drain();
      check("bypass", 64'(bus.out_verts), 64'(opk(10, 20, 30, -5, 7, -128, 127, 0, 1)));

      bus.out_ready = 1'b0;
      send(grp(100, -100, 50, 1, 2, 3, -7, 9, 127), 11585, 11585, 2'd0);
      wait_valid("bp_timeout", n);
      snap = bus.out_verts;
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = (k % 2 == 0);
         bus.in_verts = IW'({$urandom(), $urandom(), $urandom()});
         bus.axis     = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         check("bp_valid", 64'(bus.out_valid), 64'd1);
         check("bp_hold", 64'(bus.out_verts), 64'(snap));
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_ready", 64'(bus.in_ready), 64'd1);
      check("bp_release_valid", 64'(bus.out_valid), 64'd0);
      repeat (8) @(posedge clk);
      #1;
      check("bp_no_ghost", 64'(bus.out_valid), 64'd0);
      check("bp_sb_empty", 64'(sb.size()), 64'd0);

      send(g0, 5000, 15000, 2'd1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_verts", 64'(bus.out_verts), 64'd0);
      check("mid_rst_sat", 64'(bus.out_sat), 64'd0);
      check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
      void'(sb.pop_back());
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send(g0, -9000, 13000, 2'd2); drain();

      for (int r = 0; r < 8; r++) begin
         send(IW'({$urandom(), $urandom(), $urandom()}),
              int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              2'($urandom_range(0, 3)));
         drain();
      end

      #20;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
